// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: issue stage for the 3-bit ALU.
// Buffers {a, b, op} commands in a DEPTH-entry FIFO. The FIFO head drives
// the ALU operands combinationally, and the ALU result is captured into a
// registered valid/ready output. Sustains one command per clock when the
// consumer keeps up.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready           producer handshake
//   cmd_a, cmd_b, cmd_op          command payload
//   alu_a, alu_b, alu_opcode      FIFO head to ALU (all zero when empty)
//   alu_z                         ALU result (combinational)
//   res_valid/res_ready           consumer handshake
//   res_data, res_op              registered result and its opcode
//   count                         FIFO occupancy
module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int OW    = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_a,
  input  logic [AW-1:0] cmd_b,
  input  logic [OW-1:0] cmd_op,
  output logic [AW-1:0] alu_a,
  output logic [AW-1:0] alu_b,
  output logic [OW-1:0] alu_opcode,
  input  logic [AW:0]   alu_z,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW:0]   res_data,
  output logic [OW-1:0] res_op,
  output logic [CW-1:0] count
);

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [OW-1:0] op;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          nempty, push, pop;

  // cmd_ready looks only at registered occupancy. A full FIFO stays
  // closed in the cycle it pops, which keeps ready off the pop path.
  assign cmd_ready = (count < CW'(DEPTH));
  assign nempty    = (count != '0);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = nempty && (!res_valid || res_ready);

  assign head       = mem[rd_ptr];
  assign alu_a      = nempty ? head.a  : '0;
  assign alu_b      = nempty ? head.b  : '0;
  assign alu_opcode = nempty ? head.op : '0;

  // Storage is not reset. A reset zeroes the count, so stale entries are
  // never presented.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      // Issue: the head's ALU result lands in the output register as the
      // entry pops. Without a head, an accepted result only clears valid.
      if (pop) begin
        res_data  <= alu_z;
        res_op    <= head.op;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Testbench for alu_cmd_issue: queue-based reference model, ALU stub,
// directed scenarios and a randomized scoreboard run.
module tb_alu_cmd_issue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_a, cmd_b;
  logic [1:0] cmd_op;
  logic [2:0] alu_a, alu_b;
  logic [1:0] alu_opcode;
  logic [3:0] alu_z;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic [1:0] res_op;
  logic [2:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  alu_cmd_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_ref(input logic [2:0] a, input logic [2:0] b,
                                         input logic [1:0] op);
    logic [3:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a} - {1'b0, b};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  // Combinational ALU stub driven by the DUT operand outputs.
  always_comb alu_z = alu_ref(alu_a, alu_b, alu_opcode);

  // Reference model: queue of buffered commands plus the output register.
  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] op;
  } ent_t;

  ent_t       q[$];
  bit         mv;
  logic [3:0] md;
  logic [1:0] mo;

  // Advance the model with the current inputs, then clock the DUT.
  // Outputs are sampled 1 time unit after the edge.
  task automatic step();
    bit p, iss;
    p   = cmd_valid && (q.size() < DEPTH);
    iss = (q.size() > 0) && (!mv || res_ready);
    if (iss) begin
      md = alu_ref(q[0].a, q[0].b, q[0].op);
      mo = q[0].op;
      mv = 1'b1;
      void'(q.pop_front());
    end else if (mv && res_ready) begin
      mv = 1'b0;
    end
    if (p) q.push_back({cmd_a, cmd_b, cmd_op});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic [2:0] b,
                       input logic [1:0] op);
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
  endtask

  task automatic drive_rand();
    drive(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    res_ready = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 2'd0);
    q.delete(); mv = 0; md = '0; mo = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (count !== 3'd0 || res_valid !== 1'b0 || res_data !== 4'd0 || res_op !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d res_valid=%b res_data=%0d res_op=%0d, need 0/0/0/0",
               count, res_valid, res_data, res_op);
    end
    n_tests++;
    if (cmd_ready !== 1'b1 || alu_a !== 3'd0 || alu_b !== 3'd0 || alu_opcode !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: cmd_ready=%b alu=%0d/%0d/%0d, need 1 and 0/0/0",
               cmd_ready, alu_a, alu_b, alu_opcode);
    end
    rst_n = 1'b1;
    #2;
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    drive(1'b1, 3'd3, 3'd2, 2'b00);
    step();
    drive(1'b0, 3'd0, 3'd0, 2'd0);
    n_tests++;
    if (alu_a !== 3'd3 || alu_b !== 3'd2 || alu_opcode !== 2'b00 || count !== 3'd1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drive: alu=%0d/%0d/%0d count=%0d rv=%b, need 3/2/0 count=1 rv=0",
               alu_a, alu_b, alu_opcode, count, res_valid);
    end
    step();
    n_tests++;
    if (res_valid !== 1'b1 || res_data !== 4'd5 || res_op !== 2'b00 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_result: rv=%b data=%0d op=%0d count=%0d, need 1/5/0/0",
               res_valid, res_data, res_op, count);
    end
    step();
    n_tests++;
    if (res_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_retire: rv=%b count=%0d, need 0/0", res_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ta[4] = '{3'd3, 3'd1, 3'd6, 3'd4};
    logic [2:0] tb[4] = '{3'd4, 3'd2, 3'd3, 3'd1};
    logic [3:0] ex[4] = '{4'd7, 4'd15, 4'd2, 4'd5};
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, ta[i], tb[i], 2'(i));
      else       drive(1'b0, 3'd0, 3'd0, 2'd0);
      step();
      if (i >= 1) begin
        n_tests++;
        if (res_valid !== 1'b1 || res_data !== ex[i-1] || res_op !== 2'(i-1)) begin
          n_fail++;
          $display("FAIL b2b_result%0d: rv=%b data=%0d op=%0d, need 1/%0d/%0d",
                   i - 1, res_valid, res_data, res_op, ex[i-1], i - 1);
        end
      end
    end
    step();
    n_tests++;
    if (res_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_idle: rv=%b count=%0d, need 0/0", res_valid, count);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] ex[6];
    logic [1:0] eo[6];
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      ex[i] = alu_ref(cmd_a, cmd_b, cmd_op);
      eo[i] = cmd_op;
      step();
    end
    drive(1'b0, 3'd0, 3'd0, 2'd0);
    n_tests++;
    if (count !== 3'd4 || cmd_ready !== 1'b0 || res_valid !== 1'b1 ||
        res_data !== ex[0] || res_op !== eo[0]) begin
      n_fail++;
      $display("FAIL bp_full: count=%0d ready=%b rv=%b data=%0d op=%0d, need 4/0/1/%0d/%0d",
               count, cmd_ready, res_valid, res_data, res_op, ex[0], eo[0]);
    end
    res_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      n_tests++;
      if (res_valid !== 1'b1 || res_data !== ex[i] || res_op !== eo[i]) begin
        n_fail++;
        $display("FAIL bp_drain%0d: rv=%b data=%0d op=%0d, need 1/%0d/%0d",
                 i, res_valid, res_data, res_op, ex[i], eo[i]);
      end
    end
    step();
    n_tests++;
    if (res_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_empty: rv=%b count=%0d, need 0/0 (6th cmd must be dropped)",
               res_valid, count);
    end
  endtask

  task automatic test_full_no_lookahead();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      step();
    end
    res_ready = 1'b1;
    drive_rand();
    n_tests++;
    if (count !== 3'd4 || cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pre: count=%0d ready=%b rv=%b, need 4/0/1", count, cmd_ready, res_valid);
    end
    step();
    n_tests++;
    if (count !== 3'd3 || cmd_ready !== 1'b1 || res_data !== md || res_op !== mo) begin
      n_fail++;
      $display("FAIL full_pop: count=%0d ready=%b data=%0d op=%0d, need 3/1/%0d/%0d",
               count, cmd_ready, res_data, res_op, md, mo);
    end
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step();
      n_tests++;
      if (count !== 3'd3 || res_valid !== 1'b1 || res_data !== md || res_op !== mo) begin
        n_fail++;
        $display("FAIL full_steady%0d: count=%0d rv=%b data=%0d op=%0d, need 3/1/%0d/%0d",
                 i, count, res_valid, res_data, res_op, md, mo);
      end
    end
    drive(1'b0, 3'd0, 3'd0, 2'd0);
    for (int i = 0; i < 10 && (mv || q.size() > 0); i++) begin
      step();
      n_tests++;
      if (res_valid !== mv || count !== 3'(q.size()) || (mv && (res_data !== md || res_op !== mo))) begin
        n_fail++;
        $display("FAIL full_drain%0d: rv=%b count=%0d data=%0d op=%0d, need %b/%0d/%0d/%0d",
                 i, res_valid, count, res_data, res_op, mv, q.size(), md, mo);
      end
    end
  endtask

  task automatic test_wrap_random();
    logic [5:0] sb[$];
    int sent = 0;
    int cyc;
    for (cyc = 0; cyc < 300; cyc++) begin
      if (sent == 10 && sb.size() == 0) break;
      if (sent < 10 && $urandom_range(0, 3) != 0) drive_rand();
      else drive(1'b0, 3'd0, 3'd0, 2'd0);
      res_ready = 1'($urandom_range(0, 1));
      if (res_valid && res_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL wrap_extra: unexpected result data=%0d op=%0d", res_data, res_op);
        end else begin
          if ({res_data, res_op} !== sb[0]) begin
            n_fail++;
            $display("FAIL wrap_order: data=%0d op=%0d, need %0d/%0d",
                     res_data, res_op, sb[0][5:2], sb[0][1:0]);
          end
          void'(sb.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) begin
        sb.push_back({alu_ref(cmd_a, cmd_b, cmd_op), cmd_op});
        sent++;
      end
      step();
      n_tests++;
      if (count !== 3'(q.size())) begin
        n_fail++;
        $display("FAIL wrap_count: count=%0d, need %0d", count, q.size());
      end
    end
    drive(1'b0, 3'd0, 3'd0, 2'd0);
    n_tests++;
    if (cyc >= 300 || res_valid !== 1'b0 || sent != 10) begin
      n_fail++;
      $display("FAIL wrap_done: cycles=%0d sent=%0d pending=%0d rv=%b, need <300/10/0/0",
               cyc, sent, sb.size(), res_valid);
    end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      step();
    end
    drive(1'b0, 3'd0, 3'd0, 2'd0);
    n_tests++;
    if (count !== 3'd3 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: count=%0d rv=%b, need 3/1", count, res_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (count !== 3'd0 || res_valid !== 1'b0 || res_data !== 4'd0 || res_op !== 2'd0 ||
        cmd_ready !== 1'b1 || alu_a !== 3'd0 || alu_b !== 3'd0 || alu_opcode !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_async: count=%0d rv=%b data=%0d op=%0d ready=%b alu=%0d/%0d/%0d, need zeros, ready=1",
               count, res_valid, res_data, res_op, cmd_ready, alu_a, alu_b, alu_opcode);
    end
    q.delete(); mv = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (res_valid !== 1'b0 || count !== 3'd0) begin
        n_fail++;
        $display("FAIL midrst_stale%0d: rv=%b count=%0d, need 0/0", i, res_valid, count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_no_lookahead();
    test_wrap_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
